// File: rtl/latch_regfile.sv
// Latch-based register file: one masked write port, two async read ports.
// Posedge stage register feeds word enables that open latches while CK is low.
module latch_regfile #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] WM,
    input  logic [AW-1:0]    RA0,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] RD0,
    output logic [WIDTH-1:0] RD1,
    output logic             WERR
);

    logic             wa_ok;
    logic             swe_q, swe_d;
    logic [AW-1:0]    swa_q, swa_d;
    logic [WIDTH-1:0] swd_q, swd_d;
    logic [WIDTH-1:0] swm_q, swm_d;
    logic             werr_q, werr_d;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] rows [DEPTH];
    logic [WIDTH-1:0] merged;

    assign wa_ok = (int'(WA) < DEPTH);

    always_comb begin
        swe_d  = WE & wa_ok;
        werr_d = WE & ~wa_ok;
        swa_d  = WA;
        swd_d  = WD;
        swm_d  = WM;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            swe_q  <= 1'b0;
            swa_q  <= '0;
            swd_q  <= '0;
            swm_q  <= '0;
            werr_q <= 1'b0;
        end else begin
            swe_q  <= swe_d;
            swa_q  <= swa_d;
            swd_q  <= swd_d;
            swm_q  <= swm_d;
            werr_q <= werr_d;
        end
    end

    // Stage only moves while CK is high, so the enable is clean in the low phase.
    always_comb begin
        en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            en[i] = ~CK & ~RST & swe_q & (swa_q == AW'(i));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [WIDTH-1:0] word;

        // Mask acts as a data mux so every bit shares the one word enable.
        always_latch begin
            if (RST) begin
                word = '0;
            end else if (en[i]) begin
                word = (swd_q & swm_q) | (word & ~swm_q);
            end
        end

        assign rows[i] = word;
    end

    always_comb begin
        RD0 = '0;
        RD1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RA0 == AW'(i)) begin
                RD0 = rows[i];
            end
            if (RA1 == AW'(i)) begin
                RD1 = rows[i];
            end
        end
        merged = '0;
        if (BYPASS != 0 && swe_q) begin
            if (RA0 == swa_q) begin
                merged = (swd_q & swm_q) | (RD0 & ~swm_q);
                RD0    = merged;
            end
            if (RA1 == swa_q) begin
                merged = (swd_q & swm_q) | (RD1 & ~swm_q);
                RD1    = merged;
            end
        end
    end

    assign WERR = werr_q;

endmodule

// File: tb/tb_latch_regfile.sv
// Scoreboard bench: one default instance and one DEPTH=12, BYPASS=1 instance
// driven by the same directed stimulus.
module tb_latch_regfile;

    localparam int A_RD0 = 0, A_RD1 = 1, A_WERR = 2;
    localparam int B_RD0 = 3, B_RD1 = 4, B_WERR = 5;

    logic       CK, RST, WE;
    logic [3:0] WA, RA0, RA1;
    logic [7:0] WD, WM;
    logic [7:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic       a_werr, b_werr;

    int total = 0;
    int bad   = 0;

    int         qs [$];
    logic [7:0] qv [$];
    string      qn [$];
    event       sample_ev;

    latch_regfile u_a (
        .CK(CK), .RST(RST), .WE(WE), .WA(WA), .WD(WD), .WM(WM),
        .RA0(RA0), .RA1(RA1), .RD0(a_rd0), .RD1(a_rd1), .WERR(a_werr)
    );

    latch_regfile #(.WIDTH(8), .DEPTH(12), .BYPASS(1)) u_b (
        .CK(CK), .RST(RST), .WE(WE), .WA(WA), .WD(WD), .WM(WM),
        .RA0(RA0), .RA1(RA1), .RD0(b_rd0), .RD1(b_rd1), .WERR(b_werr)
    );

    initial CK = 1'b0;
    always #10 CK = ~CK;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            A_RD0:   return a_rd0;
            A_RD1:   return a_rd1;
            A_WERR:  return {7'd0, a_werr};
            B_RD0:   return b_rd0;
            B_RD1:   return b_rd1;
            default: return {7'd0, b_werr};
        endcase
    endfunction

    always begin
        @(sample_ev);
        while (qs.size() > 0) begin
            automatic int         s = qs.pop_front();
            automatic logic [7:0] v = qv.pop_front();
            automatic string      n = qn.pop_front();
            automatic logic [7:0] act = observe(s);
            total++;
            if (act !== v) begin
                bad++;
                $display("FAIL %s: got %02h expected %02h at %0t", n, act, v, $time);
            end
        end
    end

    task automatic chk(input int sel, input logic [7:0] v, input string n);
        qs.push_back(sel);
        qv.push_back(v);
        qn.push_back(n);
    endtask

    task automatic fire();
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        WE = 1'b1;
        WA = a;
        WD = d;
        WM = m;
    endtask

    task automatic rise();
        @(posedge CK);
        #1;
    endtask

    task automatic fall();
        @(negedge CK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; WE = 1'b0; WA = '0; WD = '0; WM = '0;
        RA0 = '0; RA1 = '0;
        repeat (2) @(posedge CK);
        #1;
        chk(A_WERR, 8'h00, "werr_in_rst_a");
        chk(B_WERR, 8'h00, "werr_in_rst_b");
        fire();
        fall();
        RST = 1'b0;
        for (int a = 0; a < 16; a++) begin
            RA0 = 4'(a);
            RA1 = 4'(15 - a);
            chk(A_RD0, 8'h00, "rst_rd0_a");
            chk(A_RD1, 8'h00, "rst_rd1_a");
            chk(B_RD0, 8'h00, "rst_rd0_b");
            fire();
        end
        chk(A_WERR, 8'h00, "werr_after_rst");
        fire();

        wr(4'd3, 8'hA5, 8'hFF);
        RA0 = 4'd3;
        RA1 = 4'd3;
        rise();
        WE = 1'b0;
        chk(A_RD0, 8'h00, "nobyp_before_neg");
        chk(B_RD1, 8'hA5, "byp_after_pos");
        fire();
        fall();
        chk(A_RD0, 8'hA5, "latch_open");
        fire();
        rise();
        chk(A_RD0, 8'hA5, "read_next_pos");
        chk(B_RD0, 8'hA5, "read_next_pos_b");
        fire();

        wr(4'd3, 8'h0F, 8'hF0);
        rise();
        WE = 1'b0;
        chk(B_RD1, 8'h05, "byp_masked");
        chk(A_RD1, 8'hA5, "masked_old");
        fire();
        fall();
        chk(A_RD1, 8'h05, "masked_new");
        chk(B_RD0, 8'h05, "masked_new_b");
        fire();

        RA0 = 4'd0;
        RA1 = 4'd1;
        wr(4'd0, 8'h11, 8'hFF);
        rise();
        wr(4'd1, 8'h22, 8'hFF);
        rise();
        wr(4'd0, 8'h33, 8'hFF);
        rise();
        WE = 1'b0;
        chk(B_RD0, 8'h33, "b2b_byp");
        chk(A_RD0, 8'h11, "b2b_old");
        chk(A_RD1, 8'h22, "b2b_w1");
        fire();
        rise();
        chk(A_RD0, 8'h33, "b2b_rd0_a");
        chk(A_RD1, 8'h22, "b2b_rd1_a");
        chk(B_RD0, 8'h33, "b2b_rd0_b");
        chk(B_RD1, 8'h22, "b2b_rd1_b");
        fire();

        wr(4'd13, 8'hEE, 8'hFF);
        RA0 = 4'd13;
        rise();
        WE = 1'b0;
        chk(B_WERR, 8'h01, "oor_werr");
        chk(A_WERR, 8'h00, "inrange_werr");
        chk(B_RD0, 8'h00, "oor_read");
        fire();
        fall();
        chk(A_RD0, 8'hEE, "d16_word13");
        chk(B_RD0, 8'h00, "oor_read_low");
        fire();
        rise();
        RA0 = 4'd0;
        RA1 = 4'd1;
        chk(B_WERR, 8'h00, "werr_one_cycle");
        chk(B_RD0, 8'h33, "oor_keep0");
        chk(B_RD1, 8'h22, "oor_keep1");
        fire();

        wr(4'd1, 8'hFF, 8'h00);
        rise();
        WE = 1'b0;
        chk(A_WERR, 8'h00, "noop_werr");
        chk(B_RD1, 8'h22, "noop_byp");
        fire();
        fall();
        chk(A_RD1, 8'h22, "noop_word");
        fire();

        wr(4'd5, 8'hFF, 8'hFF);
        RA0 = 4'd5;
        RA1 = 4'd0;
        rise();
        WE = 1'b0;
        fall();
        chk(A_RD0, 8'hFF, "w5_open");
        fire();
        RST = 1'b1;
        chk(A_RD0, 8'h00, "rst_mid_a0");
        chk(A_RD1, 8'h00, "rst_mid_a1");
        chk(B_RD0, 8'h00, "rst_mid_b0");
        chk(B_RD1, 8'h00, "rst_mid_b1");
        fire();
        RST = 1'b0;
        chk(A_RD0, 8'h00, "rel_low_a");
        chk(B_RD0, 8'h00, "rel_low_b");
        fire();
        rise();
        chk(A_WERR, 8'h00, "rel_werr_a");
        chk(B_WERR, 8'h00, "rel_werr_b");
        chk(A_RD0, 8'h00, "rel_word5");
        fire();

        wr(4'd5, 8'h3C, 8'hFF);
        rise();
        WE = 1'b0;
        fall();
        chk(A_RD0, 8'h3C, "post_rst_wr_a");
        chk(B_RD0, 8'h3C, "post_rst_wr_b");
        fire();

        rise();
        total++;
        if (qs.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", qs.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
